// File: rtl/regfile_pkg.sv
// Shared constants and pointer helper for the register-file write arbiter.
package regfile_pkg;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 2;
  localparam int NUM_REGS = 3;

  // A grant index outside 0..n-1 means "no transfer": the pointer stays put.
  function automatic int rr_next(input int ptr, input int g, input int n);
    if (g < 0 || g >= n) return ptr;
    return (g + 1) % n;
  endfunction
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester-side valid/ready write bus; master = requesters, slave = arbiter.
interface regfile_write_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;

  modport master (output req_valid, req_addr, req_data, input req_ready);
  modport slave  (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr.
module rr_pick #(
  parameter int N_REQ = 3,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             any_gnt
);
  int idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!any_gnt && valid[idx]) begin
        any_gnt  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = PTR_W'(idx);
      end
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter feeding the register file's single write port from an output register.
module regfile_write_arbiter #(
  parameter int N_REQ    = 3,
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int PTR_W    = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    hold,
  input  logic                    err_clear,
  regfile_write_arbiter_if.slave  rq,
  output logic                    write_enable,
  output logic [ADDR_W-1:0]       write_address,
  output logic [DATA_W-1:0]       write_data,
  output logic [PTR_W-1:0]        grant_id,
  output logic                    addr_err
);
  import regfile_pkg::*;

  logic [N_REQ-1:0]  gnt;
  logic [PTR_W-1:0]  gnt_idx;
  logic              any_gnt;
  logic              xfer;
  logic              legal;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [PTR_W-1:0]  gid_q, gid_d;
  logic              err_q, err_d;

  rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
    .valid   (rq.req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  // Ready depends only on valid, ptr, hold and reset; addr/data steer the register stage only.
  assign rq.req_ready = (reset || hold) ? '0 : gnt;

  always_comb begin
    xfer     = any_gnt && !reset && !hold;
    sel_addr = rq.req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    sel_data = rq.req_data[int'(gnt_idx)*DATA_W +: DATA_W];
    legal    = int'(sel_addr) < NUM_REGS;

    ptr_d = PTR_W'(rr_next(int'(ptr_q), xfer ? int'(gnt_idx) : N_REQ, N_REQ));
    we_d  = 1'b0;
    wa_d  = wa_q;
    wd_d  = wd_q;
    gid_d = gid_q;
    err_d = err_q && !err_clear;

    // Illegal transfers are still accepted so the requester never stalls; only the flag records them.
    if (xfer) begin
      if (legal) begin
        we_d  = 1'b1;
        wa_d  = sel_addr;
        wd_d  = sel_data;
        gid_d = gnt_idx;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      we_q  <= 1'b0;
      wa_q  <= '0;
      wd_q  <= '0;
      gid_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      we_q  <= we_d;
      wa_q  <= wa_d;
      wd_q  <= wd_d;
      gid_q <= gid_d;
      err_q <= err_d;
    end
  end

  assign write_enable  = we_q;
  assign write_address = wa_q;
  assign write_data    = wd_q;
  assign grant_id      = gid_q;
  assign addr_err      = err_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and randomized bench for regfile_write_arbiter against a cycle-level reference model.
module tb_regfile_write_arbiter;
  localparam int N = 3;

  logic clk = 1'b0;
  logic reset, hold, err_clear;
  logic       write_enable;
  logic [1:0] write_address;
  logic [7:0] write_data;
  logic [1:0] grant_id;
  logic       addr_err;

  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.N_REQ(N), .DATA_W(8), .ADDR_W(2)) rq ();

  regfile_write_arbiter #(.N_REQ(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .hold          (hold),
    .err_clear     (err_clear),
    .rq            (rq),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_data    (write_data),
    .grant_id      (grant_id),
    .addr_err      (addr_err)
  );

  // Register file behind the arbiter; its own synchronous reset blocks a commit.
  logic [7:0] regs [0:2];
  initial for (int i = 0; i < 3; i++) regs[i] = 8'h00;
  always @(posedge clk)
    if (!reset && write_enable && write_address < 2'd3) regs[write_address] <= write_data;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int m_ptr = 0, m_wa = 0, m_wd = 0, m_gid = 0;
  bit m_we = 0, m_err = 0;
  int exp_regs [3] = '{0, 0, 0};

  logic [N-1:0] v;
  logic [1:0]   a [N];
  logic [7:0]   d [N];
  bit           xfer_last [N];
  int           rdy_cnt [N];
  logic [N-1:0] rdy_obs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input bit r, input bit h);
    if (r || h) return -1;
    for (int k = 0; k < N; k++)
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic step(input bit r, input bit h, input bit c);
    int g;
    @(negedge clk);
    reset = r; hold = h; err_clear = c;
    rq.req_valid = v;
    for (int i = 0; i < N; i++) begin
      rq.req_addr[i*2 +: 2] = a[i];
      rq.req_data[i*8 +: 8] = d[i];
    end
    #1;
    g = model_pick(r, h);
    rdy_obs = rq.req_ready;
    chk("req_ready", 32'(rq.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    for (int i = 0; i < N; i++) begin
      xfer_last[i] = (g == i);
      if (g == i) rdy_cnt[i]++;
    end
    if (m_we && !r) exp_regs[m_wa] = m_wd;
    if (r) begin
      m_ptr = 0; m_we = 0; m_wa = 0; m_wd = 0; m_gid = 0; m_err = 0;
    end else if (g >= 0) begin
      m_ptr = (g + 1) % N;
      if (a[g] < 3) begin
        m_we = 1; m_wa = int'(a[g]); m_wd = int'(d[g]); m_gid = g;
        m_err = m_err && !c;
      end else begin
        m_we = 0; m_err = 1;
      end
    end else begin
      m_we = 0; m_err = m_err && !c;
    end
    @(posedge clk);
    #1;
    chk("write_enable", 32'(write_enable), 32'(m_we));
    chk("write_address", 32'(write_address), m_wa);
    chk("write_data", 32'(write_data), m_wd);
    chk("grant_id", 32'(grant_id), m_gid);
    chk("addr_err", 32'(addr_err), 32'(m_err));
    for (int i = 0; i < 3; i++) chk($sformatf("regs[%0d]", i), 32'(regs[i]), exp_regs[i]);
  endtask

  task automatic clear_reqs();
    v = '0;
    for (int i = 0; i < N; i++) begin a[i] = '0; d[i] = '0; end
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; err_clear = 1'b0;
    clear_reqs();
    rq.req_valid = '0; rq.req_addr = '0; rq.req_data = '0;
    step(1, 0, 0);
    step(1, 0, 0);
    chk("rst_we", 32'(write_enable), 32'd0);
    chk("rst_err", 32'(addr_err), 32'd0);

    // Single request from requester 1
    v = 3'b010; a[1] = 2'd2; d[1] = 8'hA5;
    step(0, 0, 0);
    chk("t1_ready", 32'(rdy_obs), 32'b010);
    chk("t1_we", 32'(write_enable), 32'd1);
    chk("t1_wa", 32'(write_address), 32'd2);
    chk("t1_wd", 32'(write_data), 32'hA5);
    chk("t1_gid", 32'(grant_id), 32'd1);
    clear_reqs();
    step(0, 0, 0);
    chk("t1_reg2", 32'(regs[2]), 32'hA5);

    // All requesters continuously valid
    step(1, 0, 0);
    for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
    v = 3'b111;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) begin a[i] = 2'(i); d[i] = 8'(8'h10 * c + i); end
      step(0, 0, 0);
      chk($sformatf("t2_gid%0d", c), 32'(grant_id), c % 3);
    end
    for (int i = 0; i < N; i++) chk($sformatf("t2_cnt%0d", i), rdy_cnt[i], 32'd2);
    clear_reqs();
    step(0, 0, 0);

    // Illegal address, clear, then clear colliding with a new illegal transfer
    v = 3'b001; a[0] = 2'd3; d[0] = 8'hFF;
    step(0, 0, 0);
    chk("t3_ready", 32'(rdy_obs), 32'b001);
    chk("t3_we", 32'(write_enable), 32'd0);
    chk("t3_err", 32'(addr_err), 32'd1);
    clear_reqs();
    step(0, 0, 1);
    chk("t3_clr", 32'(addr_err), 32'd0);
    v = 3'b001; a[0] = 2'd3; d[0] = 8'hFF;
    step(0, 0, 1);
    chk("t3_setwins", 32'(addr_err), 32'd1);
    clear_reqs();
    step(0, 0, 0);

    // Hold with all valid: pointer sits at 1 after requester 0's transfer
    v = 3'b111; a[0] = 2'd0; a[1] = 2'd1; a[2] = 2'd2;
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0);
      chk("t4_hold_ready", 32'(rdy_obs), 32'd0);
    end
    step(0, 0, 0);
    chk("t4_after_hold", 32'(rdy_obs), 32'b010);
    clear_reqs();
    step(0, 0, 0);

    // Reset while a registered write is pending
    v = 3'b001; a[0] = 2'd1; d[0] = 8'h5A;
    step(0, 0, 0);
    chk("t5_we_pending", 32'(write_enable), 32'd1);
    clear_reqs();
    step(1, 0, 0);
    chk("t5_we", 32'(write_enable), 32'd0);
    chk("t5_gid", 32'(grant_id), 32'd0);
    chk("t5_err", 32'(addr_err), 32'd0);
    step(0, 0, 0);
    chk("t5_reg1", 32'(regs[1] == 8'h5A), 32'd0);
    v = 3'b111;
    step(0, 0, 0);
    chk("t5_ptr0", 32'(rdy_obs), 32'b001);
    clear_reqs();
    for (int i = 0; i < N; i++) xfer_last[i] = 0;

    // Randomized traffic; a requester only changes its request once it has transferred
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++)
        if (xfer_last[i] || !v[i]) begin
          v[i] = 1'($urandom_range(0, 1));
          a[i] = 2'($urandom_range(0, 3));
          d[i] = 8'($urandom);
        end
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
